// File: rtl/aftab_sllu_pkg.sv
// aftab_sllu_pkg: state and selLogic encodings shared by the serial logic unit
package aftab_sllu_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam logic [1:0] SEL_XOR = 2'b00;
  localparam logic [1:0] SEL_ZERO = 2'b01;
  localparam logic [1:0] SEL_OR = 2'b10;
  localparam logic [1:0] SEL_AND = 2'b11;
endpackage

// File: rtl/aftab_llu_slice.sv
// aftab_llu_slice: CHUNK-wide combinational logic op; AFTAB_SLLU_INVB_EN enables ~B operand
module aftab_llu_slice
  import aftab_sllu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       selLogic,
  input  logic             invB,
  output logic [CHUNK-1:0] y
);
  logic [CHUNK-1:0] bEff;
`ifdef AFTAB_SLLU_INVB_EN
  assign bEff = invB ? ~b : b;
`else
  logic unusedInvB;
  assign unusedInvB = invB;
  assign bEff = b;
`endif
  always_comb
    y = selLogic == SEL_ZERO ? '0 :
        selLogic == SEL_XOR ? a ^ bEff :
        selLogic == SEL_OR ? a | bEff : a & bEff;
endmodule

// File: rtl/aftab_serial_llu.sv
// aftab_serial_llu: multi-cycle logic unit, CHUNK bits per beat with start/done handshake
// AFTAB_SLLU_INVB_EN latches invB at start and feeds ~B to the slice
module aftab_serial_llu
  import aftab_sllu_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startSLLU,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [1:0]      selLogic,
  input  logic            invB,
  output logic            busy,
  output logic            doneSLLU,
  output logic [SIZE-1:0] lluResult
);
  localparam int N = SIZE / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [SIZE-1:0] aReg, bReg, resNext;
  logic [1:0] selReg;
  logic [CHUNK-1:0] sliceOut;
  logic start, last, invEff;
`ifdef AFTAB_SLLU_INVB_EN
  logic invReg;
  always_ff @(posedge clk)
    invReg <= rst ? 1'b0 : (start ? invB : invReg);
  assign invEff = invReg;
`else
  logic unusedInvB;
  assign unusedInvB = invB;
  assign invEff = 1'b0;
`endif
  assign start = startSLLU && state != RUN;
  assign last = cnt == CW'(N - 1);
  assign busy = state == RUN;
  assign doneSLLU = state == DONE;
  always_comb
    nxt = start ? RUN : (state == RUN ? (last ? DONE : RUN) : IDLE);
  aftab_llu_slice #(.CHUNK(CHUNK)) u_slice (
    .a(aReg[CHUNK-1:0]),
    .b(bReg[CHUNK-1:0]),
    .selLogic(selReg),
    .invB(invEff),
    .y(sliceOut)
  );
  // Each beat's slice output enters at the MSB end, so the first beat ends up lowest
  generate
    if (N == 1) begin : g_one
      assign resNext = sliceOut;
    end else begin : g_many
      assign resNext = {sliceOut, lluResult[SIZE-1:CHUNK]};
    end
  endgenerate
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      aReg <= '0;
      bReg <= '0;
      selReg <= '0;
      lluResult <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        aReg <= a;
        bReg <= b;
        selReg <= selLogic;
        cnt <= '0;
        lluResult <= '0;
      end else if (state == RUN) begin
        aReg <= aReg >> CHUNK;
        bReg <= bReg >> CHUNK;
        lluResult <= resNext;
        cnt <= cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_aftab_serial_llu.sv
// tb_aftab_serial_llu: scoreboard bench for the serial logic unit (default SIZE=32, CHUNK=8)
module tb_aftab_serial_llu;
  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startSLLU = 1'b0;
  logic invB = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0] selLogic = '0;
  logic busy, doneSLLU;
  logic [31:0] lluResult;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0, busyRun = 0, dones = 0, pushes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aftab_serial_llu #(.SIZE(32), .CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .startSLLU(startSLLU),
    .a(a),
    .b(b),
    .selLogic(selLogic),
    .invB(invB),
    .busy(busy),
    .doneSLLU(doneSLLU),
    .lluResult(lluResult)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected op and checks result, timing and busy length
  always @(negedge clk) begin
    if (rst) busyRun = 0;
    else begin
      if (busy) busyRun++;
      if (doneSLLU) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: result %h with no op pending", lluResult);
        end else begin
          e = sb.pop_front();
          check("result", lluResult, e.res);
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", busyRun, 4);
          busyRun = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] s,
                       input logic inv, input logic [31:0] er, input bit push);
    @(negedge clk);
    a = ia;
    b = ib;
    selLogic = s;
    invB = inv;
    startSLLU = 1'b1;
    if (push) begin
      sb.push_back('{er, cyc + 5});
      pushes++;
    end
    @(negedge clk);
    startSLLU = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d ops pending, required 0", sb.size());
      sb.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(doneSLLU), 0);
    check("reset_result", lluResult, 0);
    rst = 1'b0;
    // T1/T2: the four ops on the same operands
    issue(32'hF0F0_1234, 32'h0FF0_00FF, 2'b00, 1'b0, 32'hFF00_12CB, 1'b1);
    drain();
    check("held_result", lluResult, 32'hFF00_12CB);
    issue(32'hF0F0_1234, 32'h0FF0_00FF, 2'b10, 1'b0, 32'hFFF0_12FF, 1'b1);
    drain();
    issue(32'hF0F0_1234, 32'h0FF0_00FF, 2'b11, 1'b0, 32'h00F0_0034, 1'b1);
    drain();
    issue(32'hF0F0_1234, 32'h0FF0_00FF, 2'b01, 1'b0, 32'h0000_0000, 1'b1);
    drain();
    // T3: second start lands in the DONE cycle of the first
    issue(32'hF0F0_1234, 32'h0FF0_00FF, 2'b00, 1'b0, 32'hFF00_12CB, 1'b1);
    repeat (3) @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1);
    drain();
    // T4: start during RUN must be ignored
    issue(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b10, 1'b0, 32'hAFAF_5F5F, 1'b1);
    issue(32'h1111_1111, 32'h2222_2222, 2'b00, 1'b0, 32'h0, 1'b0);
    drain();
    // T5: reset at RUN beat 2 discards the op
    issue(32'h1234_5678, 32'hFFFF_0000, 2'b10, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(doneSLLU), 0);
    check("rst_mid_result", lluResult, 0);
    rst = 1'b0;
    issue(32'h1234_5678, 32'hFFFF_0000, 2'b10, 1'b0, 32'hFFFF_5678, 1'b1);
    drain();
    // T6: invB only takes effect when the option is built in
`ifdef AFTAB_SLLU_INVB_EN
    issue(32'h0000_FFFF, 32'h00FF_00FF, 2'b11, 1'b1, 32'h0000_FF00, 1'b1);
`else
    issue(32'h0000_FFFF, 32'h00FF_00FF, 2'b11, 1'b1, 32'h0000_00FF, 1'b1);
`endif
    drain();
    check("done_count", dones, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
